// File: rtl/stage_mem_if.sv
// Bundle of the execute-to-memory pipeline bus and the memory stage's
// forwarding, redirect and writeback outputs.
interface stage_mem_if;
    logic [31:0] EXout_Btarg;
    logic [31:0] EXout_Jtarg;
    logic [31:0] EXout_busB;
    logic [31:0] EXout_ALUout;
    logic [4:0]  EXout_Rw;
    logic        EXout_Zero;
    logic        EXout_Overflow;
    logic        EXout_RegWr;
    logic        EXout_MemtoReg;
    logic        EXout_MemWr;
    logic        EXout_Branch;
    logic        EXout_Jump;

    logic [31:0] MEM_ALUout;
    logic [4:0]  MEM_Rw;
    logic        MEM_RegWr;
    logic        MEM_PCSrc;
    logic [31:0] MEM_NPC;
    logic        MEM_Flush;
    logic [31:0] WR_RegDin;
    logic [4:0]  WR_Rw;
    logic        WR_RegWr;
    logic        Misalign;

    // Execute-stage side
    modport master (
        output EXout_Btarg, EXout_Jtarg, EXout_busB, EXout_ALUout, EXout_Rw,
               EXout_Zero, EXout_Overflow, EXout_RegWr, EXout_MemtoReg,
               EXout_MemWr, EXout_Branch, EXout_Jump,
        input  MEM_ALUout, MEM_Rw, MEM_RegWr, MEM_PCSrc, MEM_NPC, MEM_Flush,
               WR_RegDin, WR_Rw, WR_RegWr, Misalign
    );

    // Memory-stage side
    modport slave (
        input  EXout_Btarg, EXout_Jtarg, EXout_busB, EXout_ALUout, EXout_Rw,
               EXout_Zero, EXout_Overflow, EXout_RegWr, EXout_MemtoReg,
               EXout_MemWr, EXout_Branch, EXout_Jump,
        output MEM_ALUout, MEM_Rw, MEM_RegWr, MEM_PCSrc, MEM_NPC, MEM_Flush,
               WR_RegDin, WR_Rw, WR_RegWr, Misalign
    );
endinterface

// File: rtl/stage_mem.sv
// Memory stage: EX/MEM register, data memory, branch/jump resolution,
// MEM/WR register and the forwarding buses back to execute.
module stage_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic      Clk,
    input  logic      Reset,
    stage_mem_if.slave bus
);

    // EX/MEM pipeline register
    logic [31:0] em_btarg, em_jtarg, em_busb, em_alu;
    logic [4:0]  em_rw;
    logic        em_zero, em_regwr, em_memtoreg, em_memwr, em_branch, em_jump;

    // MEM/WR pipeline register
    logic [31:0] mw_rdata, mw_alu;
    logic [4:0]  mw_rw;
    logic        mw_regwr, mw_memtoreg;

    logic        misalign;
    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rdata;
    logic              take_branch;
    logic              pcsrc;
    logic [31:0]       npc;
    logic              aligned;

    // Redirect resolution and asynchronous memory read
    always_comb begin
        word_idx    = em_alu[ADDR_W+1:2];
        rdata       = mem[word_idx];
        aligned     = (em_alu[1:0] == 2'b00);
        take_branch = em_branch & em_zero;
        pcsrc       = em_jump | take_branch;
        npc         = '0;
        if (em_jump)
            npc = em_jtarg;
        else if (take_branch)
            npc = em_btarg;
    end

    // EX/MEM capture; a redirect in MEM squashes the control bits of the
    // instruction entering behind it
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            em_btarg    <= '0;
            em_jtarg    <= '0;
            em_busb     <= '0;
            em_alu      <= '0;
            em_rw       <= '0;
            em_zero     <= 1'b0;
            em_regwr    <= 1'b0;
            em_memtoreg <= 1'b0;
            em_memwr    <= 1'b0;
            em_branch   <= 1'b0;
            em_jump     <= 1'b0;
        end else begin
            em_btarg    <= bus.EXout_Btarg;
            em_jtarg    <= bus.EXout_Jtarg;
            em_busb     <= bus.EXout_busB;
            em_alu      <= bus.EXout_ALUout;
            em_rw       <= bus.EXout_Rw;
            em_zero     <= bus.EXout_Zero;
            em_memtoreg <= bus.EXout_MemtoReg;
            em_regwr    <= ~pcsrc & bus.EXout_RegWr & ~bus.EXout_Overflow;
            em_memwr    <= ~pcsrc & bus.EXout_MemWr;
            em_branch   <= ~pcsrc & bus.EXout_Branch;
            em_jump     <= ~pcsrc & bus.EXout_Jump;
        end
    end

    // Aligned store commit; contents survive reset
    always_ff @(posedge Clk) begin
        if (!Reset && em_memwr && aligned)
            mem[word_idx] <= em_busb;
    end

    // Sticky misaligned-store flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            misalign <= 1'b0;
        else if (em_memwr && !aligned)
            misalign <= 1'b1;
    end

    // MEM/WR capture, never flushed
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mw_rdata    <= '0;
            mw_alu      <= '0;
            mw_rw       <= '0;
            mw_regwr    <= 1'b0;
            mw_memtoreg <= 1'b0;
        end else begin
            mw_rdata    <= rdata;
            mw_alu      <= em_alu;
            mw_rw       <= em_rw;
            mw_regwr    <= em_regwr;
            mw_memtoreg <= em_memtoreg;
        end
    end

    assign bus.MEM_ALUout = em_alu;
    assign bus.MEM_Rw     = em_rw;
    assign bus.MEM_RegWr  = em_regwr & (em_rw != 5'd0);
    assign bus.MEM_PCSrc  = pcsrc;
    assign bus.MEM_NPC    = npc;
    assign bus.MEM_Flush  = pcsrc;
    assign bus.WR_RegDin  = mw_memtoreg ? mw_rdata : mw_alu;
    assign bus.WR_Rw      = mw_rw;
    assign bus.WR_RegWr   = mw_regwr & (mw_rw != 5'd0);
    assign bus.Misalign   = misalign;

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
Memory stage of the 5-stage pipelined CPU. It sits directly downstream of the execute stage and holds the EX/MEM pipeline register, the data memory, branch/jump resolution and the MEM/WR pipeline register. It drives the MEM- and WR-stage forwarding buses back to the execute stage, and the redirect/flush signals to fetch.

Parameters:
DEPTH, 256, number of 32-bit data-memory words (power of two)
ADDR_W, 8, log2(DEPTH); word index = ALU address bits [ADDR_W+1:2]

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high
EXout_Btarg  in  32  branch target from execute
EXout_Jtarg  in  32  jump target from execute
EXout_busB  in  32  store data from execute
EXout_ALUout  in  32  ALU result / memory address
EXout_Rw  in  5  destination register
EXout_Zero  in  1  ALU zero flag
EXout_Overflow  in  1  ALU overflow flag
EXout_RegWr  in  1  register write enable
EXout_MemtoReg  in  1  writeback selects memory data
EXout_MemWr  in  1  memory write enable
EXout_Branch  in  1  branch instruction
EXout_Jump  in  1  jump instruction
MEM_ALUout  out  32  EX/MEM ALU result (forwarding)
MEM_Rw  out  5  EX/MEM destination (forwarding)
MEM_RegWr  out  1  EX/MEM effective write enable (forwarding)
MEM_PCSrc  out  1  redirect PC this cycle
MEM_NPC  out  32  redirect target
MEM_Flush  out  1  squash younger instructions (= MEM_PCSrc)
WR_RegDin  out  32  writeback data (forwarding and register file)
WR_Rw  out  5  writeback destination
WR_RegWr  out  1  writeback enable
Misalign  out  1  sticky misaligned-store flag

Behaviour:
- Reset (async, active-high): clear every EX/MEM and MEM/WR field and Misalign. All outputs then read 0: MEM_*, WR_*, MEM_PCSrc, MEM_NPC, MEM_Flush and Misalign. Data-memory contents are not reset.
- EX/MEM register: captures all EXout_* inputs on each rising edge. The effective RegWr is captured as EXout_RegWr & ~EXout_Overflow, so an overflowing instruction never writes back.
- Flush: if MEM_PCSrc=1 at an edge, the EX/MEM capture at that edge is squashed. RegWr, MemWr, Branch and Jump load 0; data fields load normally.
- Redirect, combinational from EX/MEM:
  - MEM_PCSrc = Jump | (Branch & Zero).
  - MEM_NPC = Jtarg if Jump, else Btarg if Branch & Zero, else 0.
  - Jump has priority over Branch.
- Data memory: word array[DEPTH], index ALUout[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Read is asynchronous.
  - Write occurs at the rising edge when MemWr=1 and ALUout[1:0]=0.
  - If MemWr=1 and ALUout[1:0]!=0, the write is suppressed and Misalign is set. Misalign stays set until Reset.
- MEM/WR register: on each edge captures read data, ALUout, Rw, effective RegWr and MemtoReg from EX/MEM. No flush applies here, because MEM-stage instructions are older than the branch.
- WR_RegDin = MemtoReg ? read data : ALUout, taken from MEM/WR.
- WR_RegWr is forced 0 when WR_Rw=0. MEM_RegWr is likewise forced 0 when MEM_Rw=0, so $0 is never forwarded.
- Latency: 1 cycle EX→MEM outputs, 2 cycles EX→WR outputs.
- Store followed by a load to the same word in the next cycle returns the new data: the write commits at the edge before the load's MEM cycle.
- Reset asserted mid-operation clears both pipeline registers immediately. A pending write is dropped if Reset is high at the edge.

Test Plan:
- ALU path: drive ALUout=0x0000_0010, Rw=5, RegWr=1, MemtoReg=0 -> next cycle MEM_ALUout=0x10, MEM_Rw=5, MEM_RegWr=1; following cycle WR_RegDin=0x10, WR_Rw=5, WR_RegWr=1.
- Store/load: store busB=0xDEADBEEF at ALUout=0x20, then load the same address with MemtoReg=1, Rw=8 -> WR_RegDin=0xDEADBEEF two cycles after the load enters. Address 0x420 with DEPTH=256 aliases the same word.
- Branch taken: Branch=1, Zero=1, Btarg=0x40 -> MEM_PCSrc=1, MEM_NPC=0x40, MEM_Flush=1. An instruction presented with RegWr=1, MemWr=1 at that edge appears with MEM_RegWr=0 and causes no memory write. Branch=1, Zero=0 -> MEM_PCSrc=0.
- Jump priority: Jump=1, Branch=1, Zero=1, Jtarg=0x100, Btarg=0x40 -> MEM_NPC=0x100.
- Overflow and $0: Overflow=1 with RegWr=1 -> MEM_RegWr=0 and WR_RegWr=0. Rw=0 with RegWr=1 -> MEM_RegWr=0 and WR_RegWr=0.
- Misalign/reset: store to 0x22 -> memory word unchanged, Misalign=1 and staying 1. Assert Reset asynchronously mid-clock -> all outputs 0 immediately, Misalign=0.
